// File: rtl/tempo_clk_divider_pkg.sv
// tempo_pkg: constants shared by the tempo divider and the music-box sequencer
package tempo_pkg;

    localparam int unsigned DEFAULT_HALF_DEF  = 150_000_000;
    localparam int          BEATS_PER_BAR_DEF = 4;

endpackage

// File: rtl/tempo_clk_divider_if.sv
// tempo_clk_divider_if: control and tempo outputs between sequencer and divider
interface tempo_clk_divider_if #(
    parameter int CNT_W  = 28,
    parameter int BEAT_W = 4
);

    logic              en;
    logic              resync;
    logic              div_load;
    logic [CNT_W-1:0]  div_value;
    logic              div_ack;
    logic              clkout;
    logic              tick;
    logic [BEAT_W-1:0] beat_idx;
    logic              bar_pulse;

    modport master (
        output en, resync, div_load, div_value,
        input  div_ack, clkout, tick, beat_idx, bar_pulse
    );

    modport slave (
        input  en, resync, div_load, div_value,
        output div_ack, clkout, tick, beat_idx, bar_pulse
    );

endinterface

// File: rtl/tempo_clk_divider_beat_counter.sv
// beat_counter: beat position within a bar with a strobe on each wrap to beat 0
module beat_counter
    import tempo_pkg::*;
#(
    parameter int BEAT_W        = 4,
    parameter int BEATS_PER_BAR = BEATS_PER_BAR_DEF
)(
    input  logic              clkin,
    input  logic              rst,
    input  logic              advance,
    input  logic              clear,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              bar_pulse
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              bar_q, bar_d;
    logic              wrap;

    assign wrap      = beat_q == BEAT_W'(BEATS_PER_BAR - 1);
    assign beat_idx  = beat_q;
    assign bar_pulse = bar_q;

    // next beat: clear wins, otherwise advance with wrap at the bar length
    always_comb begin
        beat_d = clear ? '0 : advance ? (wrap ? '0 : beat_q + 1'b1) : beat_q;
        bar_d  = !clear && advance && wrap;
    end

    // beat state register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            bar_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            bar_q  <= bar_d;
        end
    end

endmodule

// File: rtl/tempo_clk_divider.sv
// tempo_clk_divider: programmable half-period divider producing tempo, tick and beat position
module tempo_clk_divider
    import tempo_pkg::*;
#(
    parameter int          CNT_W         = 28,
    parameter int unsigned DEFAULT_HALF  = DEFAULT_HALF_DEF,
    parameter int          BEAT_W        = 4,
    parameter int          BEATS_PER_BAR = BEATS_PER_BAR_DEF
)(
    input  logic clkin,
    input  logic rst,
    tempo_clk_divider_if.slave bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             term;
    logic             advance;

    assign term        = bus.en && (cnt_q == half_q);
    assign advance     = term && !clkout_q && !bus.resync;
    assign bus.clkout  = clkout_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;

    // next state: resync beats terminal beats count; a load is staged after any
    // apply so a load on the terminal cycle waits for the following terminal
    always_comb begin
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        clkout_d   = clkout_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        if (bus.resync) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
        end else if (term) begin
            cnt_d    = '0;
            clkout_d = !clkout_q;
            tick_d   = 1'b1;
            if (pend_vld_q) begin
                half_d     = pend_val_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (bus.div_load) begin
            pend_val_d = bus.div_value;
            pend_vld_d = 1'b1;
        end
    end

    // divider state register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            half_q     <= CNT_W'(DEFAULT_HALF);
            pend_val_q <= '0;
            pend_vld_q <= 1'b0;
            clkout_q   <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            clkout_q   <= clkout_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    beat_counter #(
        .BEAT_W        (BEAT_W),
        .BEATS_PER_BAR (BEATS_PER_BAR)
    ) u_beat (
        .clkin     (clkin),
        .rst       (rst),
        .advance   (advance),
        .clear     (bus.resync),
        .beat_idx  (bus.beat_idx),
        .bar_pulse (bus.bar_pulse)
    );

endmodule

// File: tb/tb_tempo_clk_divider.sv
// tb_tempo_clk_divider: table vectors plus scoreboarded model for the tempo divider
module tb_tempo_clk_divider;

    typedef struct packed {
        logic       tick;
        logic       clkout;
        logic       ack;
        logic [3:0] beat;
        logic       bar;
    } out_t;

    typedef struct {
        logic       en;
        logic       rs;
        logic       ld;
        logic [7:0] val;
        out_t       exp;
    } vec_t;

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bars = 0;
    int   acks = 0;
    out_t exp_q[$];

    logic [7:0] m_cnt, m_half, m_pv;
    logic       m_pvld, m_clk, m_tick, m_bar, m_ack;
    logic [3:0] m_beat;

    tempo_clk_divider_if #(.CNT_W(8), .BEAT_W(4)) bus ();

    tempo_clk_divider #(
        .CNT_W         (8),
        .DEFAULT_HALF  (3),
        .BEAT_W        (4),
        .BEATS_PER_BAR (4)
    ) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clkin = !clkin;

    task automatic m_reset();
        m_cnt = 0; m_half = 3; m_pv = 0; m_pvld = 0; m_clk = 0;
        m_tick = 0; m_bar = 0; m_ack = 0; m_beat = 0;
    endtask

    task automatic m_update(input logic e, input logic r, input logic l, input logic [7:0] v);
        logic t;
        t = e && (m_cnt == m_half);
        m_tick = 0; m_bar = 0; m_ack = 0;
        if (r) begin
            m_cnt = 0; m_clk = 0; m_beat = 0;
        end else if (t) begin
            m_cnt = 0; m_tick = 1;
            if (m_pvld) begin m_half = m_pv; m_pvld = 0; m_ack = 1; end
            if (!m_clk) begin
                m_beat = (m_beat == 4'd3) ? 4'd0 : m_beat + 4'd1;
                m_bar  = (m_beat == 4'd0);
            end
            m_clk = !m_clk;
        end else if (e) begin
            m_cnt = m_cnt + 8'd1;
        end
        if (l) begin m_pv = v; m_pvld = 1; end
    endtask

    task automatic check(input string name, input out_t got, input out_t ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL %s cycle=%0d got tick=%b clk=%b ack=%b beat=%0d bar=%b exp tick=%b clk=%b ack=%b beat=%0d bar=%b",
                     name, cyc, got.tick, got.clkout, got.ack, got.beat, got.bar,
                     ex.tick, ex.clkout, ex.ack, ex.beat, ex.bar);
        end
    endtask

    function automatic out_t dut_out();
        return {bus.tick, bus.clkout, bus.div_ack, bus.beat_idx, bus.bar_pulse};
    endfunction

    task automatic step(input logic e, input logic r, input logic l, input logic [7:0] v,
                        input logic use_tbl, input out_t tx, input string name);
        bus.en = e; bus.resync = r; bus.div_load = l; bus.div_value = v;
        m_update(e, r, l, v);
        exp_q.push_back(use_tbl ? tx : out_t'({m_tick, m_clk, m_ack, m_beat, m_bar}));
        @(posedge clkin);
        #1;
        cyc++;
        check(name, dut_out(), exp_q.pop_front());
        bars += int'(bus.bar_pulse);
        acks += int'(bus.div_ack);
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, name);
    endtask

    task automatic run_until_t(input string name);
        for (int i = 0; i < 300 && m_cnt != m_half; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, name);
    endtask

    task automatic count_check(input string name, input int got, input int ex);
        checks++;
        if (got != ex) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, ex);
        end
    endtask

    vec_t tbl[12];

    initial begin
        bus.en = 0; bus.resync = 0; bus.div_load = 0; bus.div_value = 0;
        m_reset();
        for (int i = 1; i <= 12; i++) begin
            tbl[i-1].en  = 1'b1;
            tbl[i-1].rs  = 1'b0;
            tbl[i-1].ld  = 1'b0;
            tbl[i-1].val = 8'd0;
            tbl[i-1].exp = {i % 4 == 0, (i >= 4 && i < 8) || i == 12, 1'b0,
                            i >= 12 ? 4'd2 : i >= 4 ? 4'd1 : 4'd0, 1'b0};
        end
        repeat (2) @(posedge clkin);
        #1;
        check("reset_state", dut_out(), '0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            step(tbl[i].en, tbl[i].rs, tbl[i].ld, tbl[i].val, 1'b1, tbl[i].exp, "reset_release_tbl");

        run(50, "beat_run");
        count_check("bar_pulses_8_rises", bars, 2);

        run_until_t("sync_a");
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, "sync_a");
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, "sync_a");
        step(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, '0, "load1_mid");
        run(12, "load1_run");
        step(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, '0, "reload3");
        run(10, "reload3_run");

        run_until_t("sync_b");
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, "sync_b");
        acks = 0;
        step(1'b1, 1'b0, 1'b1, 8'd7, 1'b0, '0, "load7");
        step(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, '0, "load2");
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, "pre_t");
        step(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, '0, "load_on_t");
        run(12, "two_loads_run");
        count_check("acks_two_loads", acks, 2);

        run(2, "pre_freeze");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, '0, "en_low");
        run(12, "resume");

        step(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, '0, "load5");
        run(16, "load5_run");
        run_until_t("sync_c");
        run(3, "sync_c");
        step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, '0, "resync");
        run(20, "after_resync");

        step(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, '0, "load_before_rst");
        run(2, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("async_rst", dut_out(), '0);
        @(posedge clkin);
        #1 rst = 1'b0;
        m_reset();
        acks = 0;
        run(12, "post_rst");
        count_check("acks_after_rst", acks, 0);
        count_check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tempo_clk_divider.md
# tempo_clk_divider

Parametrised, runtime-programmable successor to the fixed long-period clock divider. It sits between the board clock and the music-box sequencer. It produces a 50%-duty tempo square wave, a one-cycle tick strobe at every half-period boundary, and a beat/bar position. The divisor can be reloaded on the fly with glitch-free, boundary-aligned application, plus an enable and a synchronous resync.

## Interface
Parameters:
- CNT_W, 28, counter and divisor width
- DEFAULT_HALF, 150_000_000, half-period terminal count loaded at reset (half period = DEFAULT_HALF+1 cycles)
- BEAT_W, 4, width of beat_idx
- BEATS_PER_BAR, 4, beats per bar (2..2^BEAT_W)

Ports:
- clkin  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; low freezes counter and outputs
- resync  in  1  synchronous restart pulse
- div_load  in  1  one-cycle request to stage div_value
- div_value  in  CNT_W  new half-period terminal count
- div_ack  out  1  one-cycle pulse when staged value takes effect
- clkout  out  1  tempo square wave
- tick  out  1  one-cycle strobe on every clkout toggle
- beat_idx  out  BEAT_W  current beat, 0..BEATS_PER_BAR-1
- bar_pulse  out  1  one-cycle strobe when beat_idx wraps to 0

## Operation
- Registers: counter, half_reg (active terminal), pend_val, pend_vld, clkout, beat_idx, and the strobes.
- Reset values: counter=0, half_reg=DEFAULT_HALF, pend_vld=0, clkout=0, tick=0, beat_idx=0, bar_pulse=0, div_ack=0.
- Terminal event T: en=1 and counter==half_reg. On T: counter<=0, clkout<=~clkout, tick<=1.
- When en=1 and not T: counter<=counter+1, tick<=0.
- Beat advance happens on a T where clkout goes 0->1. beat_idx<=beat_idx+1, wrapping BEATS_PER_BAR-1 -> 0. On the wrap, bar_pulse<=1 for that cycle.
- Load: when div_load=1, pend_val<=div_value and pend_vld<=1. A later load before application overwrites (latest wins, single ack).
- Apply: on a T with pend_vld=1 (staged in an earlier cycle), half_reg<=pend_val, pend_vld<=0, div_ack<=1.
- A div_load in the same cycle as T stages only. It applies at the following T.
- div_value=0 is legal: clkout toggles every enabled cycle.
- en=0: counter, clkout and beat_idx hold, and tick, bar_pulse and div_ack are 0. Loads are still staged. Application waits for a T.
- resync=1 sets counter=0, clkout=0, beat_idx=0 and clears the strobes. half_reg and the pending stage are preserved.
- Priority: rst > resync > T > count.

## Timing
- All outputs are registered. The strobes are high exactly one clkin cycle.
- With en held high after reset release, the first tick and clkout rise occur on clock edge DEFAULT_HALF+1.
- Ticks then repeat every half_reg+1 cycles. The clkout period is 2*(half_reg+1).
- A new divisor never truncates a half period. The half period starting at the applying T uses the new value.
- div_ack is coincident with the tick of the applying T.
- rst asserted mid-period forces reset values immediately, without waiting for a clock edge. Any pending load is discarded.

## Structure
- Shared package tempo_pkg holds the DEFAULT_HALF constant (150_000_000) and the BEATS_PER_BAR default, so the sequencer and the divider agree.
- Sub-module beat_counter (BEAT_W, BEATS_PER_BAR) has inputs advance and clear, and outputs beat_idx and bar_pulse. It is instantiated once.
- The top level holds the counter, the divisor staging and clkout.

## Test plan
All scenarios use CNT_W=8, DEFAULT_HALF=3, BEATS_PER_BAR=4.
- Reset release, en=1 -> tick on edges 4, 8, 12; clkout rises at 4 and falls at 8.
- After 8 clkout rises -> beat_idx runs 1,2,3,0,1,2,3,0, and bar_pulse fires at each return to 0.
- div_load with value 1 mid-period -> current period completes at 4 cycles, div_ack coincides with that tick, then ticks every 2 cycles.
- Two loads (7 then 2) before a T, and a load on a T cycle -> single ack applies 2; the T-cycle load applies one T later.
- en=0 for 5 cycles mid-count -> counter, clkout and beat_idx frozen, no tick; counting resumes with the remaining count.
- resync mid-period after loading 5, and rst asserted mid-period -> resync yields counter=0 and clkout=0 with half_reg=5 kept; rst yields all reset values, half_reg=3 and pend_vld=0.
